// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller:
// scoreboard slot layout, forwarding selects and match helpers.
package pipe_pkg;

   localparam int MAX_AW = 8;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [MAX_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
      logic [MAX_AW-1:0] rs1;
      logic [MAX_AW-1:0] rs2;
      logic              use_rs1;
      logic              use_rs2;
   } slot_t;

   // A producer slot feeds a consumer source; x0 never counts.
   function automatic logic src_hit(
      slot_t             s,
      logic [MAX_AW-1:0] rs,
      logic              use_rs
   );
      return s.valid && s.regwrite && (s.rd != '0)
          && use_rs && (s.rd == rs);
   endfunction

   function automatic logic [1:0] fwd_sel(
      slot_t             mem,
      slot_t             wb,
      logic [MAX_AW-1:0] rs,
      logic              use_rs
   );
      if (src_hit(mem, rs, use_rs))
         return FWD_MEM;
      else if (src_hit(wb, rs, use_rs))
         return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
// Asynchronous active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + W'(1);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush steering for the 5-stage pipe.
// Keeps a shadow copy of the EX, MEM and WB instructions.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter bit FWD_EN   = 1'b1,
   parameter int BR_STAGE = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              branch_taken,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              flush_exmem,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              id_fwd_a,
   output logic              id_fwd_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   slot_t id_s;
   slot_t ex_q;
   slot_t mem_q;
   slot_t wb_q;

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;
   logic hazard;

   always_comb begin
      id_s                     = '0;
      id_s.valid               = id_valid;
      id_s.rd[REG_AW-1:0]      = id_rd;
      id_s.regwrite            = id_regwrite;
      id_s.memread             = id_memread;
      id_s.rs1[REG_AW-1:0]     = id_rs1;
      id_s.rs2[REG_AW-1:0]     = id_rs2;
      id_s.use_rs1             = id_use_rs1;
      id_s.use_rs2             = id_use_rs2;
   end

   assign ex_hit  = src_hit(ex_q, id_s.rs1, id_use_rs1)
                  | src_hit(ex_q, id_s.rs2, id_use_rs2);
   assign mem_hit = src_hit(mem_q, id_s.rs1, id_use_rs1)
                  | src_hit(mem_q, id_s.rs2, id_use_rs2);
   assign wb_hit  = src_hit(wb_q, id_s.rs1, id_use_rs1)
                  | src_hit(wb_q, id_s.rs2, id_use_rs2);

   // With bypassing only a load in EX is too late to forward.
   assign hazard = FWD_EN ? (ex_hit & ex_q.memread)
                          : (ex_hit | mem_hit | wb_hit);

   assign stall       = id_valid & hazard & ~branch_taken;
   assign pc_en       = ~stall;
   assign ifid_en     = ~stall;
   assign flush_ifid  = branch_taken;
   assign flush_idex  = stall | branch_taken;
   assign flush_exmem = branch_taken & (BR_STAGE == 3);

   assign fwd_a = FWD_EN
      ? fwd_sel(mem_q, wb_q, ex_q.rs1, ex_q.valid & ex_q.use_rs1)
      : FWD_REG;
   assign fwd_b = FWD_EN
      ? fwd_sel(mem_q, wb_q, ex_q.rs2, ex_q.valid & ex_q.use_rs2)
      : FWD_REG;

   assign id_fwd_a = FWD_EN & src_hit(wb_q, id_s.rs1, id_use_rs1);
   assign id_fwd_b = FWD_EN & src_hit(wb_q, id_s.rs2, id_use_rs2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q <= mem_q;
         if (flush_exmem)
            mem_q <= '0;
         else
            mem_q <= ex_q;
         if (flush_idex)
            ex_q <= '0;
         else
            ex_q <= id_s;
      end
   end

   // Source fields of the older slots are only carried along.
   logic unused_slot;
   assign unused_slot = ^{mem_q.memread, mem_q.rs1, mem_q.rs2,
                          mem_q.use_rs1, mem_q.use_rs2,
                          wb_q.memread, wb_q.rs1, wb_q.rs2,
                          wb_q.use_rs1, wb_q.use_rs2};

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall),
      .q   (stall_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (branch_taken),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl over four configurations:
// forwarding/BR=MEM, stall-only, forwarding/BR=EX, 3-bit counters.
module tb_pipe_hazard_ctrl;

   typedef struct {
      int          d;
      string       name;
      logic [11:0] v;
      logic [11:0] m;
      int          s;
      int          f;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rn[4];
   logic       vld[4];
   logic [4:0] rs1[4];
   logic [4:0] rs2[4];
   logic [4:0] rd[4];
   logic       u1[4];
   logic       u2[4];
   logic       rw[4];
   logic       mr[4];
   logic       bt[4];

   logic        pce[4];
   logic        ife[4];
   logic        fif[4];
   logic        fix[4];
   logic        fem[4];
   logic [1:0]  fa[4];
   logic [1:0]  fb[4];
   logic        ia[4];
   logic        ib[4];
   logic        stl[4];
   logic [15:0] sc[4];
   logic [15:0] fc[4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit FW = (g != 1);
      localparam int BS = (g == 2) ? 2 : 3;
      localparam int CW = (g == 3) ? 3 : 16;
      logic [CW-1:0] sc_l;
      logic [CW-1:0] fc_l;
      pipe_hazard_ctrl #(
         .REG_AW   (5),
         .FWD_EN   (FW),
         .BR_STAGE (BS),
         .CNT_W    (CW)
      ) u_dut (
         .clk          (clk),
         .rst          (rn[g]),
         .id_valid     (vld[g]),
         .id_rs1       (rs1[g]),
         .id_rs2       (rs2[g]),
         .id_use_rs1   (u1[g]),
         .id_use_rs2   (u2[g]),
         .id_rd        (rd[g]),
         .id_regwrite  (rw[g]),
         .id_memread   (mr[g]),
         .branch_taken (bt[g]),
         .pc_en        (pce[g]),
         .ifid_en      (ife[g]),
         .flush_ifid   (fif[g]),
         .flush_idex   (fix[g]),
         .flush_exmem  (fem[g]),
         .fwd_a        (fa[g]),
         .fwd_b        (fb[g]),
         .id_fwd_a     (ia[g]),
         .id_fwd_b     (ib[g]),
         .stall        (stl[g]),
         .stall_cnt    (sc_l),
         .flush_cnt    (fc_l)
      );
      assign sc[g] = 16'(sc_l);
      assign fc[g] = 16'(fc_l);
   end

   function automatic logic [11:0] mk(
      logic pc, logic ie, logic fi, logic fx, logic fm,
      logic [1:0] a, logic [1:0] b,
      logic ja, logic jb, logic st
   );
      return {pc, ie, fi, fx, fm, a, b, ja, jb, st};
   endfunction

   function automatic logic [11:0] obs(int d);
      return {pce[d], ife[d], fif[d], fix[d], fem[d],
              fa[d], fb[d], ia[d], ib[d], stl[d]};
   endfunction

   // Monitor: everything queued this cycle is compared at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (((obs(e.d) ^ e.v) & e.m) != 12'd0) begin
               errors++;
               $display("FAIL %s dut%0d: outputs %b, required %b (care %b)",
                        e.name, e.d, obs(e.d), e.v, e.m);
            end
            if (e.s >= 0) begin
               checks++;
               if (int'(sc[e.d]) != e.s) begin
                  errors++;
                  $display("FAIL %s dut%0d stall_cnt: got %0d, required %0d",
                           e.name, e.d, sc[e.d], e.s);
               end
            end
            if (e.f >= 0) begin
               checks++;
               if (int'(fc[e.d]) != e.f) begin
                  errors++;
                  $display("FAIL %s dut%0d flush_cnt: got %0d, required %0d",
                           e.name, e.d, fc[e.d], e.f);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(int d, logic v, int r, int a, logic ua,
                      int b, logic ub, logic w, logic m);
      vld[d] = v;
      rd[d]  = 5'(r);
      rs1[d] = 5'(a);
      u1[d]  = ua;
      rs2[d] = 5'(b);
      u2[d]  = ub;
      rw[d]  = w;
      mr[d]  = m;
   endtask

   task automatic idle(int d);
      drv(d, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic putm(int d, string n, logic [11:0] v,
                       logic [11:0] m, int s, int f);
      exp_t e;
      e.d = d; e.name = n; e.v = v; e.m = m; e.s = s; e.f = f;
      sb.push_back(e);
   endtask

   task automatic put(int d, string n, logic [11:0] v, int s, int f);
      putm(d, n, v, 12'hFFF, s, f);
   endtask

   logic [11:0] norm;
   logic [11:0] stl_v;
   logic [11:0] stl_f;

   initial begin
      norm  = mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      stl_v = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1);
      stl_f = mk(0, 0, 0, 1, 0, 2'b10, 2'b00, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         rn[i] = 1'b0;
         bt[i] = 1'b0;
         idle(i);
      end

      tick();
      for (int i = 0; i < 4; i++) put(i, "reset", norm, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) rn[i] = 1'b1;

      // load-use: lw x5 ; add x6,x5,x1
      tick(); drv(0, 1, 5, 1, 1, 0, 0, 1, 1);
      put(0, "lu_lw", norm, 0, 0);
      tick(); drv(0, 1, 6, 5, 1, 1, 1, 1, 0);
      put(0, "lu_stall", stl_v, 0, 0);
      tick(); put(0, "lu_release", norm, 1, 0);
      tick(); idle(0);
      put(0, "lu_fwd_wb", mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0), 1, 0);
      tick(); put(0, "lu_drain", norm, 1, 0);
      tick(); put(0, "lu_drain", norm, 1, 0);

      // back-to-back ALU on x3
      tick(); drv(0, 1, 3, 1, 1, 2, 1, 1, 0);
      put(0, "b2b_add", norm, 1, 0);
      tick(); drv(0, 1, 4, 3, 1, 3, 1, 1, 0);
      put(0, "b2b_nostall", norm, 1, 0);
      tick(); drv(0, 1, 8, 3, 1, 9, 1, 1, 0);
      put(0, "b2b_fwd_mem", mk(1, 1, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0), 1, 0);
      tick(); drv(0, 1, 10, 3, 1, 3, 1, 1, 0);
      put(0, "b2b_fwd_wb_id", mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 1, 1, 0), 1, 0);
      tick(); idle(0); put(0, "b2b_drain", norm, 1, 0);
      tick(); put(0, "b2b_drain", norm, 1, 0);
      tick(); put(0, "b2b_drain", norm, 1, 0);

      // branch flush, BR_STAGE=3 (dut0) and BR_STAGE=2 (dut2)
      tick();
      for (int k = 0; k < 2; k++) begin
         drv(2 * k, 1, 11, 1, 1, 2, 1, 1, 0);
         put(2 * k, "br_x11", norm, -1, 0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         drv(2 * k, 1, 12, 1, 1, 2, 1, 1, 0);
         put(2 * k, "br_x12", norm, -1, 0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         drv(2 * k, 1, 13, 11, 1, 12, 1, 1, 0);
         bt[2 * k] = 1'b1;
      end
      put(0, "br_flush_mem", mk(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0, 0), -1, 0);
      put(2, "br_flush_ex", mk(1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0), -1, 0);
      tick();
      for (int k = 0; k < 2; k++) begin
         bt[2 * k] = 1'b0;
         drv(2 * k, 1, 14, 12, 1, 11, 1, 1, 0);
         put(2 * k, "br_after", mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0), -1, 1);
      end
      tick();
      for (int k = 0; k < 2; k++) idle(2 * k);
      put(0, "br_killed_nofwd", norm, 1, 1);
      put(2, "br_survivor_fwd", mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0), 0, 1);
      tick(); put(0, "br_drain", norm, 1, 1); put(2, "br_drain", norm, 0, 1);
      tick(); put(0, "br_drain", norm, 1, 1); put(2, "br_drain", norm, 0, 1);

      // branch during load-use
      tick(); drv(0, 1, 5, 1, 1, 0, 0, 1, 1);
      put(0, "pri_lw", norm, 1, 1);
      tick(); drv(0, 1, 6, 5, 1, 1, 1, 1, 0); bt[0] = 1'b1;
      put(0, "pri_branch_wins", mk(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0, 0), 1, 1);
      tick(); bt[0] = 1'b0; idle(0);
      put(0, "pri_after", norm, 1, 2);

      // x0 writer then x0 reader
      tick(); drv(0, 1, 0, 1, 1, 0, 0, 1, 1);
      put(0, "x0_lw", norm, 1, 2);
      tick(); drv(0, 1, 6, 0, 1, 0, 1, 1, 0);
      put(0, "x0_nostall", norm, 1, 2);
      tick(); idle(0); put(0, "x0_nofwd", norm, 1, 2);
      tick(); put(0, "x0_drain", norm, 1, 2);
      tick(); put(0, "x0_drain", norm, 1, 2);

      // stall-only mode: add x7 ; sub x9,x7,x7
      tick(); drv(1, 1, 7, 1, 1, 2, 1, 1, 0);
      put(1, "so_add", norm, 0, 0);
      tick(); drv(1, 1, 9, 7, 1, 7, 1, 1, 0);
      put(1, "so_stall1", stl_v, 0, 0);
      tick(); put(1, "so_stall2", stl_v, 1, 0);
      tick(); put(1, "so_stall3", stl_v, 2, 0);
      tick(); put(1, "so_release", norm, 3, 0);
      tick(); idle(1); put(1, "so_nofwd", norm, 3, 0);
      tick(); put(1, "so_drain", norm, 3, 0);
      tick(); put(1, "so_drain", norm, 3, 0);

      // reset in the middle of a stall
      tick(); drv(1, 1, 7, 1, 1, 2, 1, 1, 0);
      put(1, "rs_add", norm, 3, 0);
      tick(); drv(1, 1, 9, 7, 1, 7, 1, 1, 0);
      put(1, "rs_stall1", stl_v, 3, 0);
      tick(); put(1, "rs_stall2", stl_v, 4, 0);
      tick(); rn[0] = 1'b0; rn[1] = 1'b0;
      put(1, "rs_async", norm, 0, 0);
      put(0, "rs_async", norm, 0, 0);
      tick(); rn[0] = 1'b1; rn[1] = 1'b1;
      put(1, "rs_empty", norm, 0, 0);
      tick(); idle(1); put(1, "rs_empty_ex", norm, 0, 0);

      // saturation: lw x5,0(x5) held in ID stalls every other cycle
      for (int s = 0; s <= 20; s++) begin
         tick();
         if (s == 0) drv(3, 1, 5, 5, 1, 0, 0, 1, 1);
         if (s % 2 == 0)
            put(3, "sat_run", norm, (s / 2 > 7) ? 7 : s / 2, 0);
         else if (s == 1)
            put(3, "sat_run", stl_v, 0, 0);
         else
            put(3, "sat_run", stl_f, (s / 2 > 7) ? 7 : s / 2, 0);
      end
      tick(); idle(3); putm(3, "sat_hold", norm, 12'h000, 7, 0);
      tick(); putm(3, "sat_hold", norm, 12'h000, 7, 0);

      tick();
      tick();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0",
                  sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage pipelined CPU. It holds a shadow scoreboard of the instructions in EX, MEM and WB, and drives PC/IF-ID enables, bubble insertion, flushes and operand-forwarding selects. `FWD_EN` selects full forwarding or stall-only mode; `BR_STAGE` selects whether branches resolve in EX or MEM. It adds saturating stall and flush performance counters.

## Interface
- `REG_AW`, 5: register-address width.
- `FWD_EN`, 1: 1 = EX/MEM, MEM/WB and WB→ID forwarding; 0 = stall-only.
- `BR_STAGE`, 3: stage that asserts `branch_taken`; 2 = EX, 3 = MEM.
- `CNT_W`, 16: performance-counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_AW  source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction reads that source.
- `id_rd`  in  REG_AW  destination of the ID instruction.
- `id_regwrite`, `id_memread`  in  1  control bits of the ID instruction.
- `branch_taken`  in  1  redirect from stage `BR_STAGE`.
- `pc_en`, `ifid_en`  out  1  load enables for the PC and IF/ID.
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1  load a bubble into that register.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 register, 01 EX/MEM ALU result, 10 write-back data.
- `id_fwd_a`, `id_fwd_b`  out  1  ID operand takes write-back data.
- `stall`  out  1  load-use or data-hazard stall this cycle.
- `stall_cnt`, `flush_cnt`  out  CNT_W  performance counters.

## Operation
- **Slot contents.** Each of the EX, MEM and WB slots holds {valid, rd, regwrite, memread, rs1, rs2, use_rs1, use_rs2}.
- **Match rule.** A match requires slot valid, slot regwrite, slot rd ≠ 0, the source in use, and rd == rs.
- **Hazard, `FWD_EN`=1.** The hazard is an ID-source match against the EX slot with memread = 1 (load-use).
- **Hazard, `FWD_EN`=0.** The hazard is any ID-source match against the EX, MEM or WB slot.
- **Stall.** `stall` = `id_valid` & hazard & !`branch_taken`.
- **Forwarding, `FWD_EN`=1.**
  - `fwd_a` = 01 on an EX.rs1 match against MEM, else 10 on a match against WB, else 00. `fwd_b` uses rs2 the same way.
  - MEM has priority over WB.
  - `id_fwd_a`/`id_fwd_b` = ID-source match against WB.
- **Forwarding, `FWD_EN`=0.** All forwarding outputs are 0.
- **Stall outputs.** During a stall: `pc_en`=0, `ifid_en`=0, `flush_idex`=1. Otherwise `pc_en`=`ifid_en`=1.
- **Branch flush.** When `branch_taken`=1: `flush_ifid`=1 and `flush_idex`=1; `flush_exmem`=1 only if `BR_STAGE`=3. `branch_taken` overrides `stall`.
- **Slot update on each rising edge.**
  - WB ← MEM.
  - MEM ← EX, or invalid if `flush_exmem`.
  - EX ← the ID fields with valid = `id_valid`, or invalid if `flush_idex`.
- **Counters.** `stall_cnt` increments on cycles with `stall`=1; `flush_cnt` increments on cycles with `branch_taken`=1. Both saturate at all-ones and never wrap.

## Timing
- All steering outputs are combinational from the slot state and current inputs, with zero latency. Slots and counters are registered.
- Reset (`rst`=0, asynchronous) clears all slot valid bits and both counters immediately. Reset outputs:
  - `pc_en`=`ifid_en`=1.
  - `stall`=0.
  - all flushes 0.
  - all forwarding outputs 0.
- Reset mid-stall discards the stalled hazard; after release the pipeline starts empty.
- Load-use with `FWD_EN`=1: exactly 1 stall cycle, then `fwd`=10 for the dependent instruction in EX.
- RAW hazard with `FWD_EN`=0: the ID instruction stalls until the producer leaves WB. That is 3 cycles if the producer is in EX when the consumer enters ID.
- rd = 0 never causes a stall or a forward.
- If `branch_taken` and a hazard occur in the same cycle, only the flush takes effect; `stall_cnt` is unchanged.

## Structure
- Shared package `pipe_pkg`:
  - the slot struct typedef.
  - the `FWD_*` select encodings (`FWD_REG`=00, `FWD_MEM`=01, `FWD_WB`=10).
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `q`), instantiated twice.

## Test plan
- **Load-use.** `FWD_EN`=1; `lw x5` then `add x6,x5,x1` → one cycle with `stall`=1, `pc_en`=0 and `flush_idex`=1; next cycle `fwd_a`=10; `stall_cnt`=1.
- **Back-to-back ALU.** `FWD_EN`=1; `add x3` then `sub x4,x3,x3` → no stall; `fwd_a`=`fwd_b`=01. With a third instruction reading x3: `fwd`=10, then `id_fwd` tested at distance 3.
- **Stall-only mode.** `FWD_EN`=0; `add x7` followed immediately by a reader of x7 → 3 stall cycles, `stall_cnt`=3, all `fwd`=00.
- **Branch flush.** `BR_STAGE`=3 with `branch_taken` pulsed → `flush_ifid`=`flush_idex`=`flush_exmem`=1 for one cycle; the killed EX instruction never forwards; `flush_cnt`=1. With `BR_STAGE`=2, `flush_exmem` stays 0.
- **Priority, x0 and reset.** `branch_taken` during a load-use hazard → `stall`=0 and `stall_cnt` unchanged. A writer to x0 followed by a reader of x0 → no stall. Asserting `rst` low mid-stall → immediate `pc_en`=1 and counters=0.
- **Saturation.** `CNT_W`=3 with 10 stall cycles → `stall_cnt` holds at 7.
